zle_b_dec: RTL

- Zero run-length decoder that sits directly downstream of the ZLE encoder FSM/datapath.
- Consumes 8-bit tokens and reconstructs the original 7-bit word stream, expanding each zero-run token into the corresponding number of zero words.
- Uses the same valid/back-pressure stream protocol as the encoder: transfer occurs when v=1 and b=0.
- No EOS handling.

---
 rtl/zle_pkg.sv | 28 ++
 rtl/zle_b_dec_fsm.sv | 83 ++++++++
 rtl/zle_b_dec.sv | 91 +++++++++
 3 files changed

// File: rtl/zle_pkg.sv
// Shared constants for the zero run-length (ZLE) encoder/decoder pair.
// Holds the default word width, token layout, FSM state encodings and the
// decoder control-strobe bundle.
package zle_pkg;

   // Default data word width; a token is one bit wider (RUN flag on top).
   localparam int ZLE_W       = 7;
   localparam int ZLE_TOK_W   = ZLE_W + 1;
   // Run down-counter width; must be at least ZLE_W.
   localparam int ZLE_CW      = 7;
   // Bit position of the RUN flag inside a token.
   localparam int ZLE_RUN_BIT = ZLE_W;
   // Largest run payload; the encoder's cnt_eq_127 flag uses the same value.
   localparam logic [ZLE_W-1:0] ZLE_MAX_RUN = 7'd127;

   // Decoder FSM encodings (2-bit to stay compatible with legacy debug taps).
   localparam logic [1:0] S_PASS = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;

   // One-cycle strobes from the decoder FSM to the datapath.
   typedef struct packed {
      logic ld_lit;   // load payload as a literal word
      logic ld_run;   // load first zero of a run and the run counter
      logic dec;      // load another zero and decrement the run counter
      logic ov_clr;   // output register drained with nothing to refill
   } zle_dec_ctl_t;

endpackage

// File: rtl/zle_b_dec_fsm.sv
// Control FSM of the ZLE decoder. Owns only the state register; the
// datapath in zle_b_dec supplies the flags and acts on the strobes.
module zle_b_dec_fsm
   import zle_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         i_v,
   input  logic         out_free,
   input  logic         f_run,
   input  logic         f_payload_eq_0,
   input  logic         f_cnt_eq_1,
   output logic         i_b,
   output zle_dec_ctl_t ctl,
   output logic [1:0]   state
);

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;

   // Next-state, input back-pressure and datapath strobe decode
   always_comb begin
      state_nxt_s = state_r;
      i_b         = 1'b0;
      ctl         = zle_dec_ctl_t'(4'b0000);
      case (state_r)
         S_PASS: begin
            i_b = !out_free;
            if (i_v && out_free) begin
               if (f_run) begin
                  ctl.ld_run = 1'b1;
                  // A zero payload is a one-word run: already fully emitted.
                  if (!f_payload_eq_0) begin
                     state_nxt_s = S_RUN;
                  end else begin
                     state_nxt_s = S_PASS;
                  end
               end else begin
                  ctl.ld_lit  = 1'b1;
                  state_nxt_s = S_PASS;
               end
            end else if (out_free) begin
               ctl.ov_clr  = 1'b1;
               state_nxt_s = S_PASS;
            end else begin
               state_nxt_s = S_PASS;
            end
         end
         S_RUN: begin
            // No tokens are taken while a run is being expanded.
            i_b = 1'b1;
            if (out_free) begin
               ctl.dec = 1'b1;
               if (f_cnt_eq_1) begin
                  state_nxt_s = S_PASS;
               end else begin
                  state_nxt_s = S_RUN;
               end
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         default: begin
            // Unreachable encodings: poison outputs, recover to S_PASS.
            i_b         = 1'bx;
            ctl         = zle_dec_ctl_t'(4'bxxxx);
            state_nxt_s = S_PASS;
         end
      endcase
   end

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= S_PASS;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   assign state = state_r;

endmodule

// File: rtl/zle_b_dec.sv
// ZLE decoder top: turns W+1-bit tokens back into W-bit words. A literal
// token emits its payload; a run token emits payload+1 zero words. Both
// sides use the v/b handshake (transfer when v=1 and b=0). The output is a
// single registered entry that may drain and refill in the same cycle.
module zle_b_dec
   import zle_pkg::*;
#(
   parameter int W  = ZLE_W,
   parameter int CW = ZLE_CW
)
(
   input  logic         clock,
   input  logic         reset,
   input  logic         i_v,
   output logic         i_b,
   input  logic [W:0]   i_d,
   output logic         o_v,
   input  logic         o_b,
   output logic [W-1:0] o_d,
   output logic [1:0]   stateo
);

   localparam logic [W-1:0]  WORD_ZERO = {W{1'b0}};
   localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};

   logic         o_v_r;
   logic [W-1:0] o_d_r;
   logic [CW-1:0] cnt_r;

   logic         out_free_s;
   logic         f_run_s;
   logic         f_payload_eq_0_s;
   logic         f_cnt_eq_1_s;
   logic [W-1:0] payload_s;
   zle_dec_ctl_t ctl_s;

   assign payload_s        = i_d[W-1:0];
   assign f_run_s          = i_d[W];
   assign f_payload_eq_0_s = (payload_s == WORD_ZERO);
   assign f_cnt_eq_1_s     = (cnt_r == CNT_ONE);
   // Output slot can take a new word if empty or being drained this cycle.
   assign out_free_s       = !o_v_r || !o_b;

   zle_b_dec_fsm u_fsm (
      .clock          (clock),
      .reset          (reset),
      .i_v            (i_v),
      .out_free       (out_free_s),
      .f_run          (f_run_s),
      .f_payload_eq_0 (f_payload_eq_0_s),
      .f_cnt_eq_1     (f_cnt_eq_1_s),
      .i_b            (i_b),
      .ctl            (ctl_s),
      .state          (stateo)
   );

   // Output register and run down-counter
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         o_v_r <= 1'b0;
         o_d_r <= WORD_ZERO;
         cnt_r <= CNT_ZERO;
      end else if (ctl_s.ld_lit) begin
         o_v_r <= 1'b1;
         o_d_r <= payload_s;
         cnt_r <= cnt_r;
      end else if (ctl_s.ld_run) begin
         // First zero goes out now; cnt holds the zeros still owed.
         o_v_r <= 1'b1;
         o_d_r <= WORD_ZERO;
         cnt_r <= CW'(payload_s);
      end else if (ctl_s.dec) begin
         o_v_r <= 1'b1;
         o_d_r <= WORD_ZERO;
         cnt_r <= cnt_r - CNT_ONE;
      end else if (ctl_s.ov_clr) begin
         o_v_r <= 1'b0;
         o_d_r <= o_d_r;
         cnt_r <= cnt_r;
      end else begin
         o_v_r <= o_v_r;
         o_d_r <= o_d_r;
         cnt_r <= cnt_r;
      end
   end

   assign o_v = o_v_r;
   assign o_d = o_d_r;

endmodule
